// File: rtl/tpu_job_scheduler_pkg.sv
// Shared types for the TPU job scheduler: the descriptor layout, status codes,
// FSM encoding and the shape legality rule.
package tpu_pkg;

    localparam int MAX_DIM = 16;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ILLEGAL = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef struct packed {
        logic [8:0] offset;
        logic [4:0] k;
        logic [4:0] m;
        logic [4:0] n;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_LAUNCH, S_WAIT_ACK, S_RUN, S_REPORT
    } state_t;

    // Dims above 16 would overflow the 6-bit SRAM index of the core.
    function automatic logic dim_ok(input logic [4:0] d);
        return (d != 5'd0) && (d <= 5'(MAX_DIM));
    endfunction

    function automatic logic shape_ok(input desc_t d);
        return dim_ok(d.k) && dim_ok(d.m) && dim_ok(d.n);
    endfunction

endpackage

// File: rtl/tpu_job_scheduler_fifo.sv
// Synchronous job FIFO: registered head, no same-cycle push-to-pop bypass.
module job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tpu_job_scheduler.sv
// Front-end sequencer for the 4x4 systolic TPU: queues GEMM descriptors,
// launches one at a time, tracks the busy handshake and reports completion.
module tpu_job_scheduler
    import tpu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ID_W        = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [8:0]              job_offset,
    input  logic [4:0]              job_k,
    input  logic [4:0]              job_m,
    input  logic [4:0]              job_n,
    output logic [ID_W-1:0]         job_id,
    output logic                    tpu_in_valid,
    output logic [8:0]              tpu_input_offset,
    output logic [4:0]              tpu_K,
    output logic [4:0]              tpu_M,
    output logic [4:0]              tpu_N,
    input  logic                    tpu_busy,
    output logic                    done_valid,
    output logic [ID_W-1:0]         done_id,
    output logic [1:0]              done_status,
    output logic [$clog2(DEPTH):0]  queue_count
);
    localparam int EW = $bits(desc_t) + ID_W;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    state_t          r_state;
    desc_t           r_desc;
    logic [ID_W-1:0] r_job_id;
    logic [ID_W-1:0] r_cur_id;
    logic [ID_W-1:0] r_done_id;
    logic [1:0]      r_status;
    logic            r_in_valid;
    logic            r_done;
    logic [CW-1:0]   r_ack_cnt;

    desc_t           w_in;
    desc_t           w_head;
    logic [ID_W-1:0] w_head_id;
    logic [EW-1:0]   w_rdata;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    assign w_in      = '{offset: job_offset, k: job_k, m: job_m, n: job_n};
    assign w_push    = job_valid & ~w_full;
    // Foreign TPU activity holds off the next pop.
    assign w_pop     = (r_state == S_IDLE) & ~w_empty & ~tpu_busy;
    assign w_head    = desc_t'(w_rdata[EW-1:ID_W]);
    assign w_head_id = w_rdata[ID_W-1:0];

    job_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({w_in, r_job_id}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (queue_count)
    );

    assign job_ready        = ~w_full;
    assign job_id           = r_job_id;
    assign tpu_in_valid     = r_in_valid;
    assign tpu_input_offset = r_desc.offset;
    assign tpu_K            = r_desc.k;
    assign tpu_M            = r_desc.m;
    assign tpu_N            = r_desc.n;
    assign done_valid       = r_done;
    assign done_id          = r_done_id;
    assign done_status      = r_status;

    always_ff @(posedge clk) begin
        if (!rst_n) r_job_id <= '0;
        else if (w_push) r_job_id <= r_job_id + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_desc     <= '0;
            r_cur_id   <= '0;
            r_done_id  <= '0;
            r_status   <= ST_OK;
            r_in_valid <= 1'b0;
            r_done     <= 1'b0;
            r_ack_cnt  <= '0;
        end else begin
            r_in_valid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: if (w_pop) begin
                    r_desc   <= w_head;
                    r_cur_id <= w_head_id;
                    r_state  <= S_CHECK;
                end
                S_CHECK: if (shape_ok(r_desc)) begin
                    r_in_valid <= 1'b1;
                    r_state    <= S_LAUNCH;
                end else begin
                    r_status  <= ST_ILLEGAL;
                    r_done    <= 1'b1;
                    r_done_id <= r_cur_id;
                    r_state   <= S_REPORT;
                end
                S_LAUNCH: begin
                    r_ack_cnt <= '0;
                    r_state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: if (tpu_busy) begin
                    r_state <= S_RUN;
                end else if (r_ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
                    r_status  <= ST_TIMEOUT;
                    r_done    <= 1'b1;
                    r_done_id <= r_cur_id;
                    r_state   <= S_REPORT;
                end else begin
                    r_ack_cnt <= r_ack_cnt + 1'b1;
                end
                S_RUN: if (!tpu_busy) begin
                    r_status  <= ST_OK;
                    r_done    <= 1'b1;
                    r_done_id <= r_cur_id;
                    r_state   <= S_REPORT;
                end
                S_REPORT: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Directed bench for tpu_job_scheduler with a behavioural TPU busy model.
module tb_tpu_job_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       job_valid = 1'b0;
    logic       job_ready;
    logic [8:0] job_offset = '0;
    logic [4:0] job_k = '0, job_m = '0, job_n = '0;
    logic [3:0] job_id;
    logic       tpu_in_valid;
    logic [8:0] tpu_input_offset;
    logic [4:0] tpu_K, tpu_M, tpu_N;
    logic       tpu_busy;
    logic       done_valid;
    logic [3:0] done_id;
    logic [1:0] done_status;
    logic [2:0] queue_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_len = 20;
    int busy_cnt = 0;

    int dq_id[$], dq_st[$], dq_cyc[$], dq_k[$];
    int lq_cyc[$], lq_off[$], lq_k[$], lq_m[$], lq_n[$];

    tpu_job_scheduler dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
        .job_offset(job_offset), .job_k(job_k), .job_m(job_m), .job_n(job_n),
        .job_id(job_id), .tpu_in_valid(tpu_in_valid), .tpu_input_offset(tpu_input_offset),
        .tpu_K(tpu_K), .tpu_M(tpu_M), .tpu_N(tpu_N), .tpu_busy(tpu_busy),
        .done_valid(done_valid), .done_id(done_id), .done_status(done_status),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // TPU model: busy for busy_len cycles starting the cycle after launch; 0 = never acks.
    assign tpu_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (!rst_n) busy_cnt <= 0;
        else if (tpu_in_valid) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            dq_id.delete(); dq_st.delete(); dq_cyc.delete(); dq_k.delete();
            lq_cyc.delete(); lq_off.delete(); lq_k.delete(); lq_m.delete(); lq_n.delete();
        end else begin
            if (done_valid) begin
                dq_id.push_back(int'(done_id)); dq_st.push_back(int'(done_status));
                dq_cyc.push_back(cyc); dq_k.push_back(int'(tpu_K));
            end
            if (tpu_in_valid) begin
                lq_cyc.push_back(cyc); lq_off.push_back(int'(tpu_input_offset));
                lq_k.push_back(int'(tpu_K)); lq_m.push_back(int'(tpu_M)); lq_n.push_back(int'(tpu_N));
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        job_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Starts at posedge+1; returns at posedge+1 after the handshake cycle.
    task automatic push(input logic [8:0] off, input logic [4:0] k, m, n, output int pcyc);
        int w;
        job_valid = 1'b1; job_offset = off; job_k = k; job_m = m; job_n = n;
        w = 0;
        @(negedge clk);
        while (!job_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        pcyc = cyc;
        total++;
        if (w >= 300) begin bad++; $display("FAIL push_timeout got ready=%0b exp=1", job_ready); end
        @(posedge clk);
        #1 job_valid = 1'b0;
    endtask

    task automatic wait_dones(input int n, input int budget, output bit ok);
        int w;
        w = 0;
        while (dq_id.size() < n && w < budget) begin
            @(posedge clk);
            #1 w++;
        end
        ok = (dq_id.size() >= n);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", job_ready); end
        total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", queue_count); end
        total++; if (job_id !== 4'd0) begin bad++; $display("FAIL reset_job_id got=%0d exp=0", job_id); end
        total++; if (tpu_in_valid !== 1'b0 || done_valid !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%0b%0b exp=00", tpu_in_valid, done_valid); end
        total++; if ({tpu_input_offset, tpu_K, tpu_M, tpu_N} !== 24'd0) begin bad++; $display("FAIL reset_fields got=%h exp=0", {tpu_input_offset, tpu_K, tpu_M, tpu_N}); end
        total++; if (done_id !== 4'd0 || done_status !== 2'd0) begin bad++; $display("FAIL reset_done got=%0d/%0d exp=0/0", done_id, done_status); end
        @(posedge clk); #1;
    endtask

    task automatic test_legal();
        int pc; bit ok;
        do_reset();
        busy_len = 20;
        push(9'd128, 5'd4, 5'd4, 5'd4, pc);
        wait_dones(1, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL legal_done_seen got=%0d exp=1", dq_id.size()); end
        total++;
        if (lq_cyc.size() != 1) begin bad++; $display("FAIL legal_launch_cnt got=%0d exp=1", lq_cyc.size()); end
        else begin
            if (lq_cyc[0] != pc + 3) begin bad++; $display("FAIL legal_launch_cyc got=%0d exp=%0d", lq_cyc[0], pc + 3); end
            total++;
            if (lq_off[0] != 128 || lq_k[0] != 4 || lq_m[0] != 4 || lq_n[0] != 4) begin
                bad++; $display("FAIL legal_fields got=%0d/%0d/%0d/%0d exp=128/4/4/4", lq_off[0], lq_k[0], lq_m[0], lq_n[0]);
            end
        end
        if (ok) begin
            total++; if (dq_cyc[0] != pc + 25) begin bad++; $display("FAIL legal_done_cyc got=%0d exp=%0d", dq_cyc[0], pc + 25); end
            total++; if (dq_id[0] != 0 || dq_st[0] != 0) begin bad++; $display("FAIL legal_done got=%0d/%0d exp=0/0", dq_id[0], dq_st[0]); end
            total++; if (dq_k[0] != 4) begin bad++; $display("FAIL legal_held_K got=%0d exp=4", dq_k[0]); end
        end
    endtask

    task automatic test_illegal();
        int p0, p1; bit ok;
        do_reset();
        push(9'd0, 5'd0, 5'd4, 5'd4, p0);
        push(9'd0, 5'd4, 5'd17, 5'd4, p1);
        wait_dones(2, 60, ok);
        repeat (5) @(posedge clk);
        #1;
        total++; if (lq_cyc.size() != 0) begin bad++; $display("FAIL illegal_launch got=%0d exp=0", lq_cyc.size()); end
        total++;
        if (!ok) begin bad++; $display("FAIL illegal_done_cnt got=%0d exp=2", dq_id.size()); end
        else begin
            if (dq_id[0] != 0 || dq_id[1] != 1) begin bad++; $display("FAIL illegal_ids got=%0d,%0d exp=0,1", dq_id[0], dq_id[1]); end
            total++; if (dq_st[0] != 1 || dq_st[1] != 1) begin bad++; $display("FAIL illegal_status got=%0d,%0d exp=1,1", dq_st[0], dq_st[1]); end
            total++; if (dq_cyc[0] != p0 + 3 || dq_cyc[1] != p0 + 6) begin
                bad++; $display("FAIL illegal_cyc got=%0d,%0d exp=%0d,%0d", dq_cyc[0], dq_cyc[1], p0 + 3, p0 + 6);
            end
        end
    endtask

    task automatic test_timeout();
        int pa, pb; bit ok;
        do_reset();
        busy_len = 0;
        push(9'd7, 5'd2, 5'd3, 5'd5, pa);
        wait_dones(1, 60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL timeout_done got=%0d exp=1", dq_id.size()); end
        else begin
            if (dq_st[0] != 2 || dq_id[0] != 0) begin bad++; $display("FAIL timeout_status got=%0d/%0d exp=2/0", dq_st[0], dq_id[0]); end
            total++; if (dq_cyc[0] != pa + 12) begin bad++; $display("FAIL timeout_cyc got=%0d exp=%0d", dq_cyc[0], pa + 12); end
        end
        busy_len = 5;
        push(9'd9, 5'd16, 5'd16, 5'd16, pb);
        wait_dones(2, 60, ok);
        total++;
        if (!ok || lq_cyc.size() != 2) begin bad++; $display("FAIL timeout_next got=%0d/%0d exp=2/2", dq_id.size(), lq_cyc.size()); end
        else begin
            if (lq_cyc[1] != pb + 3) begin bad++; $display("FAIL timeout_next_launch got=%0d exp=%0d", lq_cyc[1], pb + 3); end
            total++; if (dq_id[1] != 1 || dq_st[1] != 0 || dq_cyc[1] != pb + 10) begin
                bad++; $display("FAIL timeout_next_done got=%0d/%0d@%0d exp=1/0@%0d", dq_id[1], dq_st[1], dq_cyc[1], pb + 10);
            end
        end
    endtask

    task automatic test_back_to_back();
        int p0, p, p5; bit ok;
        do_reset();
        busy_len = 30;
        push(9'd1, 5'd1, 5'd1, 5'd1, p0);
        for (int i = 1; i < 5; i++) push(9'(i), 5'd2, 5'd2, 5'd2, p);
        total++; if (queue_count !== 3'd4 || job_ready !== 1'b0) begin
            bad++; $display("FAIL bp_full got=%0d/%0b exp=4/0", queue_count, job_ready);
        end
        push(9'd5, 5'd3, 5'd3, 5'd3, p5);
        total++; if (p5 != p0 + 37) begin bad++; $display("FAIL bp_held_push got=%0d exp=%0d", p5, p0 + 37); end
        wait_dones(6, 400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_done_cnt got=%0d exp=6", dq_id.size()); end
        else for (int i = 0; i < 6; i++) begin
            if (i > 0) total++;
            if (dq_id[i] != i || dq_st[i] != 0) begin bad++; $display("FAIL bp_order[%0d] got=%0d/%0d exp=%0d/0", i, dq_id[i], dq_st[i], i); end
        end
    endtask

    task automatic test_id_wrap();
        int p; bit ok;
        do_reset();
        busy_len = 1;
        for (int i = 0; i < 18; i++) push(9'(i), 5'd4, 5'd8, 5'd12, p);
        wait_dones(18, 500, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wrap_done_cnt got=%0d exp=18", dq_id.size()); end
        else for (int i = 0; i < 18; i++) begin
            if (i > 0) total++;
            if (dq_id[i] != (i % 16)) begin bad++; $display("FAIL wrap_id[%0d] got=%0d exp=%0d", i, dq_id[i], i % 16); end
        end
    endtask

    task automatic test_reset_mid_run();
        int p;
        do_reset();
        busy_len = 40;
        for (int i = 0; i < 3; i++) push(9'd3, 5'd4, 5'd4, 5'd4, p);
        repeat (5) @(posedge clk);
        #1;
        total++; if (queue_count !== 3'd2 || !tpu_busy) begin bad++; $display("FAIL mid_pre got=%0d/%0b exp=2/1", queue_count, tpu_busy); end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        total++; if (queue_count !== 3'd0 || job_ready !== 1'b1) begin bad++; $display("FAIL mid_queue got=%0d/%0b exp=0/1", queue_count, job_ready); end
        total++; if (tpu_in_valid !== 1'b0 || done_valid !== 1'b0 || job_id !== 4'd0) begin
            bad++; $display("FAIL mid_outputs got=%0b/%0b/%0d exp=0/0/0", tpu_in_valid, done_valid, job_id);
        end
        repeat (60) @(posedge clk);
        #1;
        total++; if (dq_id.size() != 0 || lq_cyc.size() != 0) begin bad++; $display("FAIL mid_stale got=%0d/%0d exp=0/0", dq_id.size(), lq_cyc.size()); end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_id_wrap();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
